alu_sequencer: RTL and testbench

// Multi-cycle control FSM for the 32-bit ALU datapath. It runs instruction fetch, decodes the
// 5-bit opcode from IR, and issues per-cycle bus/register strobes and alu_op for ALU-class instructions.
// It sits between IR/memory interface and the register file, Y/Z/HI/LO registers and the ALU.

---
 rtl/alu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 32-bit ALU datapath: fetch, decode and
// per-cycle strobe/alu_op issue for ALU-class instructions.
module alu_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] ir_opcode,
  input  logic       mem_ack,
  output logic       pc_out,
  output logic       inc_pc,
  output logic       pc_in,
  output logic       mar_in,
  output logic       mem_rd,
  output logic       mdr_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       grb,
  output logic       grc,
  output logic       r_in,
  output logic       r_out,
  output logic       c_out,
  output logic       y_in,
  output logic       z_in,
  output logic       z_lo_out,
  output logic       z_hi_out,
  output logic       hi_in,
  output logic       lo_in,
  output logic       hi_out,
  output logic       lo_out,
  output logic [4:0] alu_op,
  output logic       run,
  output logic       illegal
);

  localparam int unsigned CW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_E1, S_E2, S_E3, S_E4, S_MD, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_UN, C_MD, C_MF, C_NOP, C_HALT, C_BAD
  } op_class_t;

  state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic      t1_wait, t1_wait_next;
  op_class_t cls;

  function automatic op_class_t classify(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return C_ALU;
      5'b01100, 5'b01101, 5'b01110:           return C_IMM;
      5'b10001, 5'b10010:                     return C_UN;
      5'b01111, 5'b10000:                     return C_MD;
      5'b10111, 5'b11000:                     return C_MF;
      5'b11001:                               return C_NOP;
      5'b11010:                               return C_HALT;
      default:                                return C_BAD;
    endcase
  endfunction

  // Immediate forms reuse the register-form ALU opcodes
  function automatic logic [4:0] imm_alu(input logic [4:0] opc);
    case (opc)
      5'b01101: return OP_AND;
      5'b01110: return OP_OR;
      default:  return OP_ADD;
    endcase
  endfunction

  assign cls = classify(ir_opcode);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      t1_wait <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      t1_wait <= t1_wait_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    t1_wait_next = 1'b0;
    pc_out = 1'b0; inc_pc = 1'b0; pc_in = 1'b0; mar_in = 1'b0;
    mem_rd = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    c_out = 1'b0; y_in = 1'b0; z_in = 1'b0; z_lo_out = 1'b0; z_hi_out = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
    alu_op = 5'b00000;
    illegal = 1'b0;
    run = (state != S_IDLE) && (state != S_HALT);

    case (state)
      S_IDLE: state_next = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        alu_op = OP_ADD;
        state_next = S_T1;
      end
      // PC reload only on the first T1 cycle; stall cycles just hold the read
      S_T1: begin
        z_lo_out = 1'b1; mem_rd = 1'b1; mdr_in = 1'b1;
        pc_in = !t1_wait;
        if (mem_ack) state_next = S_T2;
        else         t1_wait_next = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_next = S_DEC;
      end
      S_DEC: begin
        case (cls)
          C_NOP:   state_next = S_T0;
          C_HALT:  state_next = S_HALT;
          C_BAD: begin
            illegal = 1'b1;
            state_next = S_T0;
          end
          default: state_next = S_E1;
        endcase
      end
      S_E1: begin
        state_next = S_E2;
        case (cls)
          C_ALU, C_IMM: begin
            grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
          end
          C_UN: begin
            grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = ir_opcode;
          end
          C_MD: begin
            gra = 1'b1; r_out = 1'b1; y_in = 1'b1;
            cnt_next = CW'(MULDIV_CYCLES - 1);
            state_next = S_MD;
          end
          C_MF: begin
            hi_out = (ir_opcode == 5'b10111);
            lo_out = (ir_opcode != 5'b10111);
            gra = 1'b1; r_in = 1'b1;
            state_next = S_T0;
          end
          default: state_next = S_T0;
        endcase
      end
      S_E2: begin
        state_next = S_E3;
        case (cls)
          C_ALU: begin
            grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = ir_opcode;
          end
          C_IMM: begin
            c_out = 1'b1; z_in = 1'b1; alu_op = imm_alu(ir_opcode);
          end
          C_UN: begin
            z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
            state_next = S_T0;
          end
          default: state_next = S_T0;
        endcase
      end
      // Multi-cycle mul/div: operand held on the bus, result captured on the last cycle
      S_MD: begin
        grb = 1'b1; r_out = 1'b1; alu_op = ir_opcode;
        if (cnt == '0) begin
          z_in = 1'b1;
          state_next = S_E3;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      S_E3: begin
        z_lo_out = 1'b1;
        if (cls == C_MD) begin
          lo_in = 1'b1;
          state_next = S_E4;
        end else begin
          gra = 1'b1; r_in = 1'b1;
          state_next = S_T0;
        end
      end
      S_E4: begin
        z_hi_out = 1'b1; hi_in = 1'b1;
        state_next = S_T0;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle strobe vectors and alu_op
// checked against hand-written expectations.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] ir_opcode;
  logic       mem_ack;
  logic pc_out, inc_pc, pc_in, mar_in, mem_rd, mdr_in, mdr_out, ir_in;
  logic gra, grb, grc, r_in, r_out, c_out, y_in, z_in, z_lo_out, z_hi_out;
  logic hi_in, lo_in, hi_out, lo_out, run, illegal;
  logic [4:0] alu_op;

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [23:0] PC_OUT  = 24'(1) << 23;
  localparam logic [23:0] INC_PC  = 24'(1) << 22;
  localparam logic [23:0] PC_IN   = 24'(1) << 21;
  localparam logic [23:0] MAR_IN  = 24'(1) << 20;
  localparam logic [23:0] MEM_RD  = 24'(1) << 19;
  localparam logic [23:0] MDR_IN  = 24'(1) << 18;
  localparam logic [23:0] MDR_OUT = 24'(1) << 17;
  localparam logic [23:0] IR_IN   = 24'(1) << 16;
  localparam logic [23:0] GRA     = 24'(1) << 15;
  localparam logic [23:0] GRB     = 24'(1) << 14;
  localparam logic [23:0] GRC     = 24'(1) << 13;
  localparam logic [23:0] R_IN    = 24'(1) << 12;
  localparam logic [23:0] R_OUT   = 24'(1) << 11;
  localparam logic [23:0] C_OUT   = 24'(1) << 10;
  localparam logic [23:0] Y_IN    = 24'(1) << 9;
  localparam logic [23:0] Z_IN    = 24'(1) << 8;
  localparam logic [23:0] Z_LO    = 24'(1) << 7;
  localparam logic [23:0] Z_HI    = 24'(1) << 6;
  localparam logic [23:0] HI_IN   = 24'(1) << 5;
  localparam logic [23:0] LO_IN   = 24'(1) << 4;
  localparam logic [23:0] HI_OUT  = 24'(1) << 3;
  localparam logic [23:0] LO_OUT  = 24'(1) << 2;
  localparam logic [23:0] RUN     = 24'(1) << 1;
  localparam logic [23:0] ILLEGAL = 24'(1);
  localparam logic [23:0] T0_B    = PC_OUT | MAR_IN | INC_PC | Z_IN | RUN;
  localparam logic [23:0] T1_B    = Z_LO | MEM_RD | MDR_IN | RUN;
  localparam logic [23:0] T2_B    = MDR_OUT | IR_IN | RUN;

  logic [23:0] sig;
  assign sig = {pc_out, inc_pc, pc_in, mar_in, mem_rd, mdr_in, mdr_out, ir_in,
                gra, grb, grc, r_in, r_out, c_out, y_in, z_in, z_lo_out, z_hi_out,
                hi_in, lo_in, hi_out, lo_out, run, illegal};

  alu_sequencer #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .ir_opcode(ir_opcode), .mem_ack(mem_ack),
    .pc_out(pc_out), .inc_pc(inc_pc), .pc_in(pc_in), .mar_in(mar_in),
    .mem_rd(mem_rd), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
    .c_out(c_out), .y_in(y_in), .z_in(z_in), .z_lo_out(z_lo_out),
    .z_hi_out(z_hi_out), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out),
    .lo_out(lo_out), .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] exp_b, input logic [4:0] exp_a);
    n_cmp++;
    assert (sig === exp_b) else begin
      n_fail++;
      $error("FAIL %s strobes: observed %h expected %h", tag, sig, exp_b);
    end
    n_cmp++;
    assert (alu_op === exp_a) else begin
      n_fail++;
      $error("FAIL %s alu_op: observed %b expected %b", tag, alu_op, exp_a);
    end
  endtask

  // From a checked T0: T1 (stall+1 cycles), T2, ending in DEC
  task automatic fetch(input int stall);
    tick();
    for (int i = 0; i <= stall; i++) begin
      chk("t1", T1_B | ((i == 0) ? PC_IN : 24'(0)), 5'b00000);
      mem_ack = (i == stall);
      tick();
    end
    mem_ack = 1'b0;
    chk("t2", T2_B, 5'b00000);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    ir_opcode = 5'b00000;
    mem_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("idle", 24'(0), 5'b00000);
    tick();
    chk("t0_first", T0_B, 5'b00011);

    // add with ack on the first T1 cycle
    ir_opcode = 5'b00011;
    fetch(0);
    chk("add_dec", RUN, 5'b00000);
    tick(); chk("add_e1", GRB | R_OUT | Y_IN | RUN, 5'b00000);
    tick(); chk("add_e2", GRC | R_OUT | Z_IN | RUN, 5'b00011);
    tick(); chk("add_e3", Z_LO | GRA | R_IN | RUN, 5'b00000);
    tick(); chk("add_t0", T0_B, 5'b00011);

    // nop with a 3-cycle fetch stall
    ir_opcode = 5'b11001;
    fetch(3);
    chk("nop_dec", RUN, 5'b00000);
    tick(); chk("nop_t0", T0_B, 5'b00011);

    // mul: four MD cycles, z_in on the last
    ir_opcode = 5'b01111;
    fetch(0);
    chk("mul_dec", RUN, 5'b00000);
    tick(); chk("mul_e1", GRA | R_OUT | Y_IN | RUN, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mul_md", GRB | R_OUT | RUN | ((i == 3) ? Z_IN : 24'(0)), 5'b01111);
    end
    tick(); chk("mul_e3", Z_LO | LO_IN | RUN, 5'b00000);
    tick(); chk("mul_e4", Z_HI | HI_IN | RUN, 5'b00000);
    tick(); chk("mul_t0", T0_B, 5'b00011);

    // neg
    ir_opcode = 5'b10001;
    fetch(0);
    chk("neg_dec", RUN, 5'b00000);
    tick(); chk("neg_e1", GRB | R_OUT | Z_IN | RUN, 5'b10001);
    tick(); chk("neg_e2", Z_LO | GRA | R_IN | RUN, 5'b00000);
    tick(); chk("neg_t0", T0_B, 5'b00011);

    // mfhi
    ir_opcode = 5'b10111;
    fetch(0);
    chk("mfhi_dec", RUN, 5'b00000);
    tick(); chk("mfhi_e1", HI_OUT | GRA | R_IN | RUN, 5'b00000);
    tick(); chk("mfhi_t0", T0_B, 5'b00011);

    // unsupported opcode
    ir_opcode = 5'b11111;
    fetch(0);
    chk("ill_dec", RUN | ILLEGAL, 5'b00000);
    tick(); chk("ill_t0", T0_B, 5'b00011);

    // div aborted by reset in MD
    ir_opcode = 5'b10000;
    fetch(0);
    chk("div_dec", RUN, 5'b00000);
    tick(); chk("div_e1", GRA | R_OUT | Y_IN | RUN, 5'b00000);
    tick(); chk("div_md0", GRB | R_OUT | RUN, 5'b10000);
    tick(); chk("div_md1", GRB | R_OUT | RUN, 5'b10000);
    reset_n = 1'b0;
    tick(); chk("div_rst_idle", 24'(0), 5'b00000);
    reset_n = 1'b1;
    tick(); chk("div_rst_t0", T0_B, 5'b00011);

    // addi after restart
    ir_opcode = 5'b01100;
    fetch(0);
    chk("addi_dec", RUN, 5'b00000);
    tick(); chk("addi_e1", GRB | R_OUT | Y_IN | RUN, 5'b00000);
    tick(); chk("addi_e2", C_OUT | Z_IN | RUN, 5'b00011);
    tick(); chk("addi_e3", Z_LO | GRA | R_IN | RUN, 5'b00000);
    tick(); chk("addi_t0", T0_B, 5'b00011);

    // ori maps to the OR ALU opcode
    ir_opcode = 5'b01110;
    fetch(0);
    chk("ori_dec", RUN, 5'b00000);
    tick(); chk("ori_e1", GRB | R_OUT | Y_IN | RUN, 5'b00000);
    tick(); chk("ori_e2", C_OUT | Z_IN | RUN, 5'b00110);
    tick(); chk("ori_e3", Z_LO | GRA | R_IN | RUN, 5'b00000);
    tick(); chk("ori_t0", T0_B, 5'b00011);

    // halt: stuck with run low until reset
    ir_opcode = 5'b11010;
    fetch(0);
    chk("halt_dec", RUN, 5'b00000);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halt", 24'(0), 5'b00000);
    end
    mem_ack = 1'b0;
    reset_n = 1'b0;
    tick(); chk("halt_rst_idle", 24'(0), 5'b00000);
    reset_n = 1'b1;
    tick(); chk("halt_rst_t0", T0_B, 5'b00011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
